// File: rtl/mem_copy_engine.sv
// Bulk-data sequencer for the single-port data memory: byte-at-a-time block copy
// (read then write, ascending) or constant fill, launched by one start pulse.
module mem_copy_engine #(
  parameter int W = 8,
  parameter int A = 8
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         start,
  input  logic         mode,
  input  logic [A-1:0] src_addr,
  input  logic [A-1:0] dst_addr,
  input  logic [A:0]   length,
  input  logic [W-1:0] fill_value,
  input  logic         abort,
  input  logic [W-1:0] mem_data_in,
  output logic [A-1:0] mem_addr,
  output logic [W-1:0] mem_data_out,
  output logic         mem_read_en,
  output logic         mem_write_en,
  output logic         busy,
  output logic         done
);

  typedef enum logic [2:0] {
    S_IDLE,
    S_RD,
    S_WR,
    S_FILL,
    S_DONE
  } state_t;

  state_t       r_state;
  state_t       w_next;
  logic [A-1:0] r_src_ptr;
  logic [A-1:0] r_dst_ptr;
  logic [A:0]   r_remaining;
  logic [W-1:0] r_hold;
  logic [W-1:0] r_fill;

  logic         w_rd;
  logic         w_wr;
  logic [A-1:0] w_addr;
  logic [W-1:0] w_wdata;
  logic         w_last;

  assign w_last = (r_remaining == (A+1)'(1));

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_state     <= S_IDLE;
      r_src_ptr   <= '0;
      r_dst_ptr   <= '0;
      r_remaining <= '0;
      r_hold      <= '0;
      r_fill      <= '0;
    end else begin
      r_state <= w_next;
      case (r_state)
        S_IDLE: begin
          if (start) begin
            r_src_ptr   <= src_addr;
            r_dst_ptr   <= dst_addr;
            r_remaining <= length;
            r_fill      <= fill_value;
          end
        end
        S_RD: begin
          if (!abort) begin
            r_hold    <= mem_data_in;
            r_src_ptr <= r_src_ptr + A'(1);
          end
        end
        S_WR, S_FILL: begin
          if (!abort) begin
            r_dst_ptr   <= r_dst_ptr + A'(1);
            r_remaining <= r_remaining - (A+1)'(1);
          end
        end
        default: ;
      endcase
    end
  end

  // An aborted cycle issues no access and lands in DONE so done still pulses.
  always_comb begin
    w_next  = r_state;
    w_rd    = 1'b0;
    w_wr    = 1'b0;
    w_addr  = '0;
    w_wdata = '0;
    case (r_state)
      S_IDLE: begin
        if (start) begin
          if (length == '0) w_next = S_DONE;
          else if (mode)    w_next = S_FILL;
          else              w_next = S_RD;
        end
      end
      S_RD: begin
        if (abort) begin
          w_next = S_DONE;
        end else begin
          w_rd   = 1'b1;
          w_addr = r_src_ptr;
          w_next = S_WR;
        end
      end
      S_WR: begin
        if (abort) begin
          w_next = S_DONE;
        end else begin
          w_wr    = 1'b1;
          w_addr  = r_dst_ptr;
          w_wdata = r_hold;
          w_next  = w_last ? S_DONE : S_RD;
        end
      end
      S_FILL: begin
        if (abort) begin
          w_next = S_DONE;
        end else begin
          w_wr    = 1'b1;
          w_addr  = r_dst_ptr;
          w_wdata = r_fill;
          w_next  = w_last ? S_DONE : S_FILL;
        end
      end
      S_DONE:  w_next = S_IDLE;
      default: w_next = S_IDLE;
    endcase
  end

  assign mem_read_en  = w_rd;
  assign mem_write_en = w_wr;
  assign mem_addr     = w_addr;
  assign mem_data_out = w_wdata;
  assign busy         = (r_state != S_IDLE);
  assign done         = (r_state == S_DONE);

endmodule

// File: tb/tb_mem_copy_engine.sv
// Directed bench for mem_copy_engine: per-cycle expected port activity is queued
// from a behavioural model when each operation is launched, then popped and compared.
module tb_mem_copy_engine;
  localparam int W = 8;
  localparam int A = 8;

  logic         clk = 1'b0;
  logic         reset;
  logic         start;
  logic         mode;
  logic [A-1:0] src_addr;
  logic [A-1:0] dst_addr;
  logic [A:0]   length;
  logic [W-1:0] fill_value;
  logic         abort;
  logic [W-1:0] mem_data_in;
  logic [A-1:0] mem_addr;
  logic [W-1:0] mem_data_out;
  logic         mem_read_en;
  logic         mem_write_en;
  logic         busy;
  logic         done;

  logic [7:0] mem     [256];
  logic [7:0] ref_mem [256];

  typedef struct packed {
    logic       rd;
    logic       wr;
    logic [7:0] addr;
    logic [7:0] data;
    logic       bsy;
    logic       dn;
  } exp_t;

  exp_t expq[$];
  int   total = 0;
  int   bad   = 0;

  always #5 clk = ~clk;

  assign mem_data_in = mem[mem_addr];
  always @(posedge clk) if (mem_write_en) mem[mem_addr] <= mem_data_out;

  mem_copy_engine #(.W(W), .A(A)) dut (
    .clk          (clk),
    .reset        (reset),
    .start        (start),
    .mode         (mode),
    .src_addr     (src_addr),
    .dst_addr     (dst_addr),
    .length       (length),
    .fill_value   (fill_value),
    .abort        (abort),
    .mem_data_in  (mem_data_in),
    .mem_addr     (mem_addr),
    .mem_data_out (mem_data_out),
    .mem_read_en  (mem_read_en),
    .mem_write_en (mem_write_en),
    .busy         (busy),
    .done         (done)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp_v);
    total++;
    assert (obs === exp_v) else begin
      bad++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp_v);
    end
  endtask

  task automatic push_exp(input logic rd, input logic wr, input logic [7:0] addr,
                          input logic [7:0] data, input logic bsy, input logic dn);
    exp_t e;
    e.rd = rd; e.wr = wr; e.addr = addr; e.data = data; e.bsy = bsy; e.dn = dn;
    expq.push_back(e);
  endtask

  // Behavioural model: one queue entry per cycle after the start edge, plus a trailing idle cycle.
  task automatic plan(input logic md, input logic [7:0] s, input logic [7:0] d,
                      input int unsigned len, input logic [7:0] fv, input int unsigned ab);
    int unsigned c = 0;
    logic        aborted = 1'b0;
    logic [7:0]  v;
    for (int unsigned i = 0; i < len && !aborted; i++) begin
      if (!md) begin
        c++;
        if (c == ab) begin
          push_exp(0, 0, 8'h00, 8'h00, 1, 0);
          aborted = 1'b1;
        end else begin
          v = ref_mem[8'(s + i)];
          push_exp(1, 0, 8'(s + i), 8'h00, 1, 0);
          c++;
          if (c == ab) begin
            push_exp(0, 0, 8'h00, 8'h00, 1, 0);
            aborted = 1'b1;
          end else begin
            push_exp(0, 1, 8'(d + i), v, 1, 0);
            ref_mem[8'(d + i)] = v;
          end
        end
      end else begin
        c++;
        if (c == ab) begin
          push_exp(0, 0, 8'h00, 8'h00, 1, 0);
          aborted = 1'b1;
        end else begin
          push_exp(0, 1, 8'(d + i), fv, 1, 0);
          ref_mem[8'(d + i)] = fv;
        end
      end
    end
    push_exp(0, 0, 8'h00, 8'h00, 1, 1);
    push_exp(0, 0, 8'h00, 8'h00, 0, 0);
  endtask

  task automatic sample(input string tag, input int unsigned cyc);
    exp_t  e;
    string t;
    e = expq.pop_front();
    t = $sformatf("%s.c%0d", tag, cyc);
    chk({t, ".rd"},   32'(mem_read_en),  32'(e.rd));
    chk({t, ".wr"},   32'(mem_write_en), 32'(e.wr));
    chk({t, ".addr"}, 32'(mem_addr),     32'(e.addr));
    chk({t, ".data"}, 32'(mem_data_out), 32'(e.data));
    chk({t, ".busy"}, 32'(busy),         32'(e.bsy));
    chk({t, ".done"}, 32'(done),         32'(e.dn));
  endtask

  task automatic run(input string tag, input logic md, input logic [7:0] s, input logic [7:0] d,
                     input int unsigned len, input logic [7:0] fv, input int unsigned ab);
    plan(md, s, d, len, fv, ab);
    mode = md; src_addr = s; dst_addr = d; length = 9'(len); fill_value = fv;
    start = 1'b1;
    @(posedge clk);
    #1 start = 1'b0;
    for (int unsigned c = 1; expq.size() > 0; c++) begin
      if (c > 1) begin
        @(posedge clk);
        #1;
      end
      abort = (c == ab);
      @(negedge clk);
      sample(tag, c);
    end
    abort = 1'b0;
  endtask

  task automatic check_mem(input string tag);
    for (int unsigned i = 0; i < 256; i++)
      chk($sformatf("%s.mem%02h", tag, i), 32'(mem[i]), 32'(ref_mem[i]));
  endtask

  task automatic check_quiet(input string tag);
    chk({tag, ".rd"},   32'(mem_read_en),  32'd0);
    chk({tag, ".wr"},   32'(mem_write_en), 32'd0);
    chk({tag, ".addr"}, 32'(mem_addr),     32'd0);
    chk({tag, ".data"}, 32'(mem_data_out), 32'd0);
    chk({tag, ".busy"}, 32'(busy),         32'd0);
    chk({tag, ".done"}, 32'(done),         32'd0);
  endtask

  initial begin
    reset = 1'b0; start = 1'b0; mode = 1'b0; abort = 1'b0;
    src_addr = '0; dst_addr = '0; length = '0; fill_value = '0;
    for (int unsigned i = 0; i < 256; i++) begin
      mem[i]     = 8'($urandom);
      ref_mem[i] = mem[i];
    end

    #1 check_quiet("rst_held0");
    repeat (2) @(posedge clk);
    #1 check_quiet("rst_held1");
    @(negedge clk) reset = 1'b1;
    @(negedge clk) check_quiet("rst_after");

    // Basic copy
    for (int unsigned i = 0; i < 4; i++) begin
      mem[8'h10 + i]     = 8'(8'h11 * (i + 1));
      ref_mem[8'h10 + i] = mem[8'h10 + i];
    end
    run("copy", 1'b0, 8'h10, 8'h80, 4, 8'h00, 0);
    check_mem("copy");
    chk("copy.m80", 32'(mem[8'h80]), 32'h11);
    chk("copy.m83", 32'(mem[8'h83]), 32'h44);

    // Fill across the address wrap
    run("fillwrap", 1'b1, 8'h00, 8'hFE, 4, 8'hA5, 0);
    check_mem("fillwrap");
    chk("fillwrap.mFF", 32'(mem[8'hFF]), 32'hA5);
    chk("fillwrap.m01", 32'(mem[8'h01]), 32'hA5);

    // Zero length
    run("zero", 1'b0, 8'h20, 8'h30, 0, 8'h77, 0);
    check_mem("zero");

    // Overlapping ascending copy smears the first byte
    for (int unsigned i = 0; i < 4; i++) begin
      mem[i]     = 8'(i + 1);
      ref_mem[i] = 8'(i + 1);
    end
    run("overlap", 1'b0, 8'h00, 8'h01, 3, 8'h00, 0);
    for (int unsigned i = 0; i < 4; i++)
      chk($sformatf("overlap.m%0d", i), 32'(mem[i]), 32'h01);

    // Abort during the third read
    run("abort", 1'b0, 8'h50, 8'h60, 8, 8'h00, 5);
    check_mem("abort");
    run("postabort", 1'b1, 8'h00, 8'hC0, 3, 8'h5A, 0);
    check_mem("postabort");

    // Reset mid-fill, with a start pulse while busy that must be ignored
    mode = 1'b1; dst_addr = 8'h40; length = 9'd16; fill_value = 8'h3C;
    start = 1'b1;
    @(posedge clk);
    #1 start = 1'b0;
    for (int unsigned c = 1; c <= 5; c++) begin
      if (c > 1) begin
        @(posedge clk);
        #1;
      end
      if (c == 3) begin
        start = 1'b1; mode = 1'b0; dst_addr = 8'h90; length = 9'd2;
      end else begin
        start = 1'b0;
      end
      @(negedge clk);
      chk($sformatf("rstfill.c%0d.wr", c),   32'(mem_write_en), 32'd1);
      chk($sformatf("rstfill.c%0d.addr", c), 32'(mem_addr),     32'(8'h40 + c - 1));
      chk($sformatf("rstfill.c%0d.data", c), 32'(mem_data_out), 32'h3C);
      chk($sformatf("rstfill.c%0d.busy", c), 32'(busy),         32'd1);
      ref_mem[8'h40 + c - 1] = 8'h3C;
    end
    @(posedge clk);
    #1 reset = 1'b0;
    #1 check_quiet("rstfill.assert");
    for (int unsigned k = 0; k < 3; k++) begin
      @(negedge clk);
      check_quiet($sformatf("rstfill.hold%0d", k));
    end
    @(posedge clk);
    #1 reset = 1'b1;
    @(negedge clk);
    check_quiet("rstfill.release");
    check_mem("rstfill");

    run("afterrst", 1'b0, 8'h40, 8'hA0, 3, 8'h00, 0);
    check_mem("afterrst");

    // Whole-memory fill
    run("fullfill", 1'b1, 8'h00, 8'h37, 256, 8'hC3, 0);
    check_mem("fullfill");

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/mem_copy_engine.md
Name: mem_copy_engine

Overview:
- Initiator-side sequencer that drives the single-port data memory's port: addr, data_to_write, read_enabled and write_enabled, and consumes its combinational data_out.
- Performs block copy (src to dst) or block fill (constant to dst) of up to 2**A bytes on one start pulse.
- Sits beside the core as a bulk-data helper. Arbitration with the core's load/store path is handled outside this block; the engine owns the memory port while busy=1.

Parameters:
- W, 8, data width of one memory entry (bits)
- A, 8, address width; memory depth 2**A

Ports:
- clk, input, 1, single clock; all state updates on posedge
- reset, input, 1, asynchronous active-low reset (0 = reset)
- start, input, 1, begin operation; sampled only in IDLE
- mode, input, 1, 0 = copy, 1 = fill; captured at start
- src_addr, input, A, copy source base; captured at start; ignored in fill
- dst_addr, input, A, destination base; captured at start
- length, input, A+1, byte count 0..2**A; captured at start
- fill_value, input, W, fill constant; captured at start
- abort, input, 1, synchronous cancel of an active operation
- mem_data_in, input, W, memory data_out (combinational read result)
- mem_addr, output, A, memory address
- mem_data_out, output, W, memory data_to_write
- mem_read_en, output, 1, memory read_enabled
- mem_write_en, output, 1, memory write_enabled
- busy, output, 1, operation in progress
- done, output, 1, one-cycle completion pulse

Behaviour:
- States: IDLE, RD, WR, FILL, DONE.
- Reset (reset=0, asynchronous):
  - state = IDLE; pointers, counter and hold register = 0.
  - mem_addr, mem_data_out, mem_read_en, mem_write_en, busy and done all read 0 while reset is held and after release.
- Reset mid-operation: immediate return to IDLE. No further writes; no done pulse.
- IDLE, start=1 at an edge: capture all operand inputs. Next state:
  - length=0: DONE. No memory access.
  - mode=0: RD.
  - mode=1: FILL.
- start while not in IDLE is ignored.
- RD:
  - mem_read_en=1, mem_addr=src_ptr.
  - At the edge, mem_data_in is latched into the hold register; src_ptr increments; go to WR.
- WR:
  - mem_write_en=1, mem_addr=dst_ptr, mem_data_out=hold.
  - At the edge, dst_ptr increments and remaining decrements. Go to DONE if remaining was 1, else RD.
- FILL:
  - mem_write_en=1, mem_addr=dst_ptr, mem_data_out=fill_value.
  - At the edge, dst_ptr increments and remaining decrements. Go to DONE if remaining was 1.
- DONE: done=1 for exactly one cycle, then IDLE.
- busy=1 in RD, WR, FILL and DONE; 0 in IDLE.
- mem_read_en and mem_write_en are never both 1. Both are 0 in IDLE and DONE. mem_addr and mem_data_out are 0 whenever their enable is low.
- Latency after the start edge:
  - Copy of N bytes: 2N access cycles, then the done cycle (done on cycle 2N+1).
  - Fill of N bytes: done on cycle N+1.
  - length=0: done on cycle 1.
- Address wrap: pointers are A bits and wrap modulo 2**A, e.g. src 0xFF followed by 0x00.
- length=2**A covers the whole memory.
- Overlap: copy is strictly ascending and byte-at-a-time (read, then write).
  - With dst>src and overlapping ranges, source bytes are overwritten before they are read. This is defined behaviour, not an error.
- abort=1 in RD, WR or FILL:
  - That cycle's access is suppressed (both enables 0).
  - Next state is DONE, so done still pulses.
  - abort in IDLE or DONE has no effect.
- abort and reset together: reset wins.

Test Plan:
- Copy: mem[0x10..0x13]=11,22,33,44; start mode=0 src=0x10 dst=0x80 len=4 -> 8 alternating RD/WR cycles, addr sequence 10,80,11,81,12,82,13,83; mem[0x80..0x83]=11,22,33,44; done on cycle 9; busy high cycles 1..9.
- Fill with wrap: start mode=1 dst=0xFE len=4 fill_value=0xA5 -> writes at FE,FF,00,01 = A5; done on cycle 5; mem[0x02] unchanged.
- Zero length: start len=0 -> no enables asserted; done=1 on cycle 1; busy=1 only on that cycle.
- Overlap: mem[0..3]=1,2,3,4; copy src=0 dst=1 len=3 -> mem[0..3]=1,1,1,1.
- Abort: copy len=8, assert abort during the 3rd RD (cycle 5) -> no enables that cycle; done on cycle 6; only 2 bytes written; start in a later IDLE is accepted.
- Reset mid-fill: drop reset during FILL of len=16 after 5 writes -> outputs 0 immediately; 5 bytes written; no done; start after release behaves normally. Also check that start while busy is ignored.
